fetch_issue_ctrl: RTL
=====================

Name: fetch_issue_ctrl

Overview:
- Instruction-fetch sequencer placed in front of hazard_detection.
- Owns the PC and issues reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned 24-bit instructions in a small FIFO and presents them to hazard_detection under a valid/stall handshake.
- Handles branch redirects (flush plus discard of the in-flight read) and stops fetching after a HALT opcode.

Parameters:
- PC_W, 12: PC / instruction-memory address width; matches the 12-bit address field.
- DEPTH, 2: instruction buffer entries; power of two, at least 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_rd_en  out  1  read strobe to instruction memory.
- imem_addr  out  PC_W  read address; valid when imem_rd_en=1.
- imem_rdata  in  24  read data, valid on the cycle after imem_rd_en.
- instr_out  out  24  instruction at the buffer head.
- instr_pc  out  PC_W  address of instr_out.
- instr_valid  out  1  buffer non-empty.
- stall_in  in  1  from hazard_detection; 1 means hold instr_out.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  PC_W  new fetch address.
- halted  out  1  high while in HALT state.

Behaviour:
- Instruction fields: opcode [23:18], mode [17:16], reg [15:12], imm/addr [11:0]. OP_HALT = 6'h3F.
- Reset (async, rst_n=0):
  - pc=RESET_PC, buffer empty, in-flight flag cleared, state=RUN.
  - All outputs 0: imem_rd_en, instr_valid, halted, instr_out, instr_pc.
  - Fetching starts on the first clk edge after release.
  - Reset asserted mid-operation discards buffered and in-flight data; the late imem_rdata is ignored.
- Consume: occurs when instr_valid=1 and stall_in=0. The head is popped at that edge.
- Issue condition in RUN, with redirect_valid=0: (count + inflight - consume) < DEPTH.
  - When met: imem_rd_en=1, imem_addr=pc, and pc <= pc+1, wrapping from 2^PC_W-1 to 0.
  - inflight <= 1, recording the issued address for instr_pc.
  - Sustains 1 instruction/cycle when stall_in=0.
  - First instr_valid appears 2 cycles after reset release.
- Return: the cycle after an issue, imem_rdata is pushed with its PC unless the read has been killed.
  - Push and pop in the same cycle are legal; count is unchanged.
  - The buffer can never overflow; an overflow is an assertion failure.
- Stall: while stall_in=1, instr_out and instr_pc are held stable. Fetching continues until the buffer is full, then imem_rd_en=0.
- Redirect (highest priority, any state):
  - Flush the buffer at the edge.
  - Kill the in-flight read; its data is never pushed.
  - pc <= redirect_pc, state <= RUN.
  - No issue in the redirect cycle; the first fetch from redirect_pc is on the next cycle.
  - A head consumed in the same cycle as a redirect counts as delivered.
  - Back-to-back redirects: the last one wins.
- States:
  - RUN: normal issue. When a pushed instruction has opcode OP_HALT, go to HALT and kill any in-flight read issued after it.
  - HALT: no issue, halted=1. The buffer still drains normally. Leave HALT only on redirect_valid, to RUN, or on reset.
- instr_valid is 0 whenever the buffer is empty. instr_out and instr_pc are don't-care when invalid but stay at their last values (no X).

Decomposition:
- Shared package risc_net_pkg holds:
  - INSTR_W=24
  - field bit-range constants: OPC_HI/LO, MODE, REG, IMM
  - OP_HALT
  - state enum {ST_RUN, ST_HALT}
- One sub-module, instr_fifo: DEPTH-entry FIFO of {pc, instr} with push/pop/flush, count, full and empty. It is reusable by other pipeline stages.

Test Plan:
- Streaming: imem holds 24'h010004, 24'h113006, 24'h0C6008, 24'h123006 at 0..3; stall_in=0 -> instr_valid rises at cycle 2 after reset; instr_out sequence matches with instr_pc 0,1,2,3 on consecutive cycles.
- Stall: assert stall_in for 4 cycles while instr_out=24'h113006 -> output held; imem_rd_en drops once count=2; after release, the order resumes with no loss or duplicate.
- Redirect: redirect_valid with redirect_pc=12'h020 while a read of addr 3 is in flight -> buffer flushed; addr-3 data never appears; next imem_addr=12'h020; next instr_pc=12'h020.
- HALT: 24'hFC0000 at addr 2 -> state HALT, halted=1, no imem_rd_en after it; addrs 0..2 drain; redirect to 12'h000 clears halted and refetches.
- Wrap: redirect_pc=12'hFFE -> fetches 12'hFFE, 12'hFFF, 12'h000.
- Async reset mid-stream: drop rst_n between clock edges -> all outputs 0 immediately; pending read data ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/risc_net_pkg.sv
// Shared definitions for the fetch/decode pipeline: instruction layout,
// special opcodes and the fetch-sequencer state encoding.
package risc_net_pkg;

    localparam int INSTR_W = 24;

    // Instruction field bit ranges.
    localparam int OPC_HI  = 23;
    localparam int OPC_LO  = 18;
    localparam int MODE_HI = 17;
    localparam int MODE_LO = 16;
    localparam int REG_HI  = 15;
    localparam int REG_LO  = 12;
    localparam int IMM_HI  = 11;
    localparam int IMM_LO  = 0;

    localparam logic [OPC_HI-OPC_LO:0] OP_HALT = 6'h3F;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_e;

endpackage

// File: rtl/instr_fifo.sv
// Small power-of-two FIFO with synchronous flush. Generic enough to carry
// any {tag, payload} word between pipeline stages.
module instr_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 36,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; an entry is only
        // ever read after it has been written, so clearing it buys nothing.
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single-cycle-latency
// reads to instruction memory, buffers the returned words and hands them to
// hazard detection under a valid/stall handshake. Handles branch redirects
// and parks in HALT once a HALT opcode has been fetched.
module fetch_issue_ctrl
    import risc_net_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               stall_in,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = PC_W + INSTR_W;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [ENT_W-1:0]  hold_q;

    logic [CNT_W-1:0]  fifo_count, occupancy;
    logic              fifo_full, fifo_empty;
    logic [ENT_W-1:0]  fifo_head, shown;
    logic              consume, push, halt_push, issue;

    assign consume   = ~fifo_empty & ~stall_in;
    // A redirect kills the returning read: its data is dropped, not pushed.
    assign push      = inflight_q & ~redirect_valid;
    assign halt_push = push & (state_q == ST_RUN) & (imem_rdata[OPC_HI:OPC_LO] == OP_HALT);

    // Slots already claimed once this cycle's pop is accounted for.
    assign occupancy = fifo_count + CNT_W'(inflight_q) - CNT_W'(consume);
    // rst_n gates issue so the strobe is low during reset yet the first read
    // goes out on the very first edge after release.
    assign issue     = rst_n & (state_q == ST_RUN) & ~redirect_valid
                     & (occupancy < CNT_W'(DEPTH));

    assign imem_rd_en  = issue;
    assign imem_addr   = pc_q;
    assign instr_valid = ~fifo_empty;
    assign halted      = (state_q == ST_HALT);

    // When the buffer is empty the outputs keep showing the last head.
    assign shown                 = fifo_empty ? hold_q : fifo_head;
    assign {instr_pc, instr_out} = shown;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (consume),
        .flush_i (redirect_valid),
        .wdata_i ({inflight_pc_q, imem_rdata}),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next PC, in-flight tracking and RUN/HALT sequencing; redirect has top priority.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned and infers a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            state_d = ST_RUN;
            pc_d    = redirect_pc;
        end else begin
            if (issue) begin
                pc_d          = pc_q + PC_W'(1);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            // A read issued alongside the HALT push is dead on arrival.
            if (halt_push) begin
                state_d    = ST_HALT;
                inflight_d = 1'b0;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Remember what is on the outputs so they stay put while the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= shown;
    end

    // The issue throttle must make a push into a full, non-draining buffer impossible.
    overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
                                  !(push && fifo_full && !consume));

endmodule
